// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game slice: the 2-bit key/light code
// constants, the key encoder FSM state encoding, the stability counter
// width and small helpers used when a debounced press is accepted.
package simon_pkg;

  // Width of the debounce stability counter.
  localparam int unsigned CNT_W = 20;

  // Key / light codes. The key encoder and the light sequencer use the
  // same encoding so a pressed key can be compared directly to a light.
  typedef logic [1:0] code_t;

  localparam code_t KEY0 = 2'b00;
  localparam code_t KEY1 = 2'b01;
  localparam code_t KEY2 = 2'b10;
  localparam code_t KEY3 = 2'b11;

  // Key encoder FSM states.
  typedef enum logic [1:0] {
    S_IDLE         = 2'b00,
    S_DEBOUNCE     = 2'b01,
    S_WAIT_RELEASE = 2'b10
  } key_state_t;

  // True when exactly one bit of the pressed vector is set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Code of a single pressed key. Only meaningful for one-hot input.
  function automatic code_t encode_key(input logic [3:0] v);
    code_t c;
    c = KEY0;
    unique case (v)
      4'b0001: c = KEY0;
      4'b0010: c = KEY1;
      4'b0100: c = KEY2;
      4'b1000: c = KEY3;
      default: c = KEY0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the four raw active-low pushbuttons.
// The inversion is done in front of the first flop, so both flops hold the
// "pressed" sense and reset to all-zero (no key pressed).
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   key_n    raw pushbuttons, active-low, asynchronous to clk
//   pressed  synchronized pressed vector (1 = key down)
module key_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic [3:0] pressed
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta    <= '0;
      pressed <= '0;
    end else begin
      meta    <= ~key_n;
      pressed <= meta;
    end
  end

endmodule

// File: rtl/key_press_encoder.sv
// Debounces four pushbuttons and encodes a single accepted key press into a
// 2-bit code. A press must be stable for DEBOUNCE_CYCLES cycles to be
// accepted; a one-hot press pulses key_valid, a multi-key press pulses
// key_error. After acceptance the FSM waits for a debounced release before
// another press can be taken, so a held key reports exactly once.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   key_n      raw pushbuttons, active-low, asynchronous to clk
//   enable     1 = new presses are accepted
//   key_valid  one-cycle pulse: single-key press accepted
//   key_code   code of the last accepted key, held until next key_valid
//   key_error  one-cycle pulse: debounced press had several keys down
//   busy       registered decode of state != IDLE
module key_press_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       enable,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       key_error,
  output logic       busy
);

  import simon_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       p;
  key_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       smp, smp_d;
  logic             key_valid_d;
  logic             key_error_d;
  code_t            key_code_d;
  logic             busy_d;

  key_sync u_key_sync (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .pressed (p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      smp       <= '0;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      key_code  <= KEY0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      smp       <= smp_d;
      key_valid <= key_valid_d;
      key_error <= key_error_d;
      key_code  <= key_code_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    smp_d       = smp;
    key_valid_d = 1'b0;
    key_error_d = 1'b0;
    key_code_d  = key_code;

    unique case (state)
      S_IDLE: begin
        if (enable && (p != '0)) begin
          state_d = S_DEBOUNCE;
          smp_d   = p;
          cnt_d   = '0;
        end
      end

      S_DEBOUNCE: begin
        // Any change in the pressed set (key added, removed or bounce) or
        // loss of enable abandons this press without reporting anything.
        if ((p != smp) || !enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = S_WAIT_RELEASE;
          cnt_d   = '0;
          if (is_one_hot(smp)) begin
            key_valid_d = 1'b1;
            key_code_d  = encode_key(smp);
          end else begin
            key_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_WAIT_RELEASE: begin
        // Enable is deliberately ignored: the release must always complete.
        if (p != '0) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Decoded from the next state so the registered busy tracks state.
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_key_press_encoder.sv
module tb_key_press_encoder;

  logic       clk;
  logic       reset;
  logic [3:0] key_n;
  logic       enable;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_error;
  logic       busy;

  int total;
  int bad;
  int vcount;
  int ecount;
  int both_count;

  key_press_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .enable    (enable),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_error (key_error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key_n;
    logic       en;
    int         cycles;
    int         exp_valid;
    int         exp_err;
    logic [1:0] exp_code;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance n clock edges, sampling outputs 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (key_valid) vcount++;
      if (key_error) ecount++;
      if (key_valid && key_error) both_count++;
    end
  endtask

  initial begin
    total = 0; bad = 0; vcount = 0; ecount = 0; both_count = 0;
    reset = 1'b0; key_n = 4'b1111; enable = 1'b0;

    // Reset state
    #12;
    check("rst_valid", int'(key_valid), 0);
    check("rst_error", int'(key_error), 0);
    check("rst_code",  int'(key_code),  0);
    check("rst_busy",  int'(busy),      0);
    reset = 1'b1;
    step(2);

    //           key_n    en    cyc  v  e  code   busy
    tbl[0]  = '{4'b1110, 1'b1, 20,  1, 0, 2'b00, 1'b1};
    tbl[1]  = '{4'b1111, 1'b1, 10,  0, 0, 2'b00, 1'b0};
    tbl[2]  = '{4'b0111, 1'b1, 100, 1, 0, 2'b11, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 10,  0, 0, 2'b11, 1'b0};
    tbl[4]  = '{4'b1010, 1'b1, 20,  0, 1, 2'b11, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 10,  0, 0, 2'b11, 1'b0};
    tbl[6]  = '{4'b1011, 1'b0, 20,  0, 0, 2'b11, 1'b0};
    tbl[7]  = '{4'b1011, 1'b1, 20,  1, 0, 2'b10, 1'b1};
    tbl[8]  = '{4'b1111, 1'b0, 10,  0, 0, 2'b10, 1'b0};
    tbl[9]  = '{4'b1101, 1'b1, 3,   0, 0, 2'b10, 1'b1};
    tbl[10] = '{4'b1111, 1'b1, 10,  0, 0, 2'b10, 1'b0};

    for (int r = 0; r < 11; r++) begin
      key_n  = tbl[r].key_n;
      enable = tbl[r].en;
      vcount = 0;
      ecount = 0;
      step(tbl[r].cycles);
      check($sformatf("vec%0d_valid_cnt", r), vcount, tbl[r].exp_valid);
      check($sformatf("vec%0d_error_cnt", r), ecount, tbl[r].exp_err);
      check($sformatf("vec%0d_code", r), int'(key_code), int'(tbl[r].exp_code));
      check($sformatf("vec%0d_busy", r), int'(busy), int'(tbl[r].exp_busy));
    end

    // Exact acceptance latency: pulse after edge 7 counting the first
    // sampling edge as edge 1, single-cycle wide.
    enable = 1'b1;
    key_n  = 4'b1110;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check($sformatf("lat_valid_e%0d", i), int'(key_valid), (i == 7) ? 1 : 0);
    end
    check("lat_code", int'(key_code), 0);
    step(1);
    check("lat_pulse_width", int'(key_valid), 0);
    step(3);
    // Release: busy drops on the 6th edge after key_n goes high.
    key_n = 4'b1111;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      check($sformatf("rel_busy_e%0d", i), int'(busy), (i < 6) ? 1 : 0);
    end

    // Bounce on KEY1 then stable hold.
    vcount = 0; ecount = 0;
    for (int k = 0; k < 15; k++) begin
      key_n = (k % 2 == 0) ? 4'b1101 : 4'b1111;
      step(2);
    end
    check("bounce_valid_cnt", vcount, 0);
    check("bounce_error_cnt", ecount, 0);
    key_n = 4'b1101;
    step(20);
    check("bounce_hold_valid_cnt", vcount, 1);
    check("bounce_hold_code", int'(key_code), 1);
    key_n = 4'b1111;
    step(10);
    check("bounce_rel_busy", int'(busy), 0);

    // Reset in the middle of DEBOUNCE (cnt=2) with KEY2 held.
    vcount = 0; ecount = 0;
    key_n = 4'b1011;
    step(5);
    check("pre_rst_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_busy",  int'(busy),      0);
    check("mid_rst_code",  int'(key_code),  0);
    step(2);
    #2;
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check($sformatf("post_rst_valid_e%0d", i), int'(key_valid), (i == 7) ? 1 : 0);
    end
    check("post_rst_code", int'(key_code), 2);
    step(10);
    check("post_rst_valid_cnt", vcount, 1);
    check("post_rst_error_cnt", ecount, 0);
    key_n = 4'b1111;
    step(10);
    check("post_rst_rel_busy", int'(busy), 0);

    check("valid_error_exclusive", both_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_press_encoder.md
KEY_PRESS_ENCODER -- requirements
Module: key_press_encoder

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), number of consecutive stable cycles required to accept a press or a release; legal range 2..2^20-1.
REQ-002 clk  input  1  single system clock; all state SHALL change on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 key_n  input  4  raw pushbuttons, active-low, asynchronous to clk.
REQ-005 enable  input  1  high = new presses accepted (player input phase).
REQ-006 key_valid  output  1  one-cycle pulse: a debounced single-key press was accepted.
REQ-007 key_code  output  2  code of the last accepted key: KEY0=00, KEY1=01, KEY2=10, KEY3=11 (same encoding as the light code); valid with key_valid and held until the next key_valid.
REQ-008 key_error  output  1  one-cycle pulse: debounced press had more than one key down.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; pressed vector p = ~synchronized key_n.
REQ-011 FSM states SHALL be IDLE, DEBOUNCE, WAIT_RELEASE; one 20-bit stability counter cnt; a 4-bit captured vector smp.
REQ-012 IDLE: if enable=1 and p!=0 -> DEBOUNCE with smp<=p and cnt<=0; otherwise stay.
REQ-013 DEBOUNCE: if p!=smp or enable=0 -> IDLE with cnt<=0 and no output pulse.
REQ-014 DEBOUNCE: if p==smp, cnt increments; when cnt==DEBOUNCE_CYCLES-1 -> WAIT_RELEASE with cnt<=0.
REQ-015 On that DEBOUNCE exit, if smp is one-hot, key_valid SHALL pulse for exactly one cycle and key_code SHALL be updated in the same cycle; otherwise key_error SHALL pulse for one cycle and key_code SHALL be unchanged.
REQ-016 WAIT_RELEASE: p!=0 clears cnt; p==0 increments cnt; at cnt==DEBOUNCE_CYCLES-1 with p==0 -> IDLE; enable is ignored in this state.
REQ-017 Latency: key_valid SHALL assert on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge at which key_n is sampled stable-low.
REQ-018 A held key SHALL produce exactly one key_valid; no re-trigger until a full release debounce completes.
REQ-019 key_valid and key_error SHALL never be high in the same cycle; at most one pulse per press.
REQ-020 A key added or removed during DEBOUNCE SHALL restart acceptance from IDLE (glitch rejection).
REQ-021 busy SHALL be a registered decode of state != IDLE.

Reset
REQ-022 reset=0 SHALL immediately force: state IDLE, cnt 0, smp 0, synchronizer flops 0 (no key pressed), key_valid 0, key_error 0, key_code 00, busy 0.
REQ-023 Reset asserted mid-DEBOUNCE or mid-WAIT_RELEASE SHALL discard the press with no pulse; after release, a still-held key SHALL be treated as a new press.

Structure
REQ-024 Shared package simon_pkg SHALL hold the 2-bit key/light code constants (KEY0..KEY3) and the FSM state encoding.
REQ-025 The synchronizer SHALL be a separate sub-module key_sync (4-bit, 2-flop, async active-low reset).
REQ-026 Only the DEBOUNCE_CYCLES parameter SHALL be local; the counter width SHALL be 20 bits.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 key_n=1110 held 20 cycles, enable=1 -> single key_valid pulse, key_code=00, on edge 7 after first low sample; busy high until 4 cycles after release.
REQ-028 key_n=0111 held 100 cycles -> exactly one key_valid, key_code=11; no further pulses until release completes.
REQ-029 key_n=1010 (KEY0+KEY2) held 20 cycles -> one key_error pulse, no key_valid, key_code unchanged.
REQ-030 key_n toggles 1101/1111 every 2 cycles for 30 cycles, then 1101 held -> no pulse during bounce; one key_valid, code=01, after stable hold.
REQ-031 enable=0 with key_n=1011 held -> no pulse, busy 0; raise enable while held -> key_valid code=10 after 4+1 cycles.
REQ-032 reset pulsed low at cnt=2 of DEBOUNCE with key held -> outputs 0 immediately; after reset release, key_valid fires once per REQ-017.
